retire_multi: RTL and testbench
===============================

# retire_multi

Parametrised multi-wide in-order retirement unit between the reorder buffer and the rename/free-list, store buffer, BTB and fetch redirect logic. Each cycle it examines up to RETIRE_WIDTH consecutive entries from the ROB head and retires the longest legal in-order prefix. It generates per-slot architectural commits, at most one BTB update, and store releases. A registered redirect/flush follows a retired mispredicted control-flow instruction. A retired SYSTEM instruction parks the block in a halt state.

## Interface
- ADDR_WIDTH, 32, PC/address width (targetPC is full width).
- DATA_WIDTH, 32, datapath width (no datapath use; kept for uniformity).
- NUM_ROB_ENTRY, 16, ROB depth; power of two.
- RETIRE_WIDTH, 2, slots examined per cycle; 1..4, ≤ NUM_ROB_ENTRY.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  external pipeline flush; kills retirement this cycle and returns FSM to RUN.
- ROB_FINISH  in  NUM_ROB_ENTRY  per-entry completed flag.
- ROB  in  ROB_ENTRY_t[NUM_ROB_ENTRY]  ROB contents (opcode, rd_arch, rd_phy_old/new, addr, update_pc, actual_taken, actual_target, mispredict).
- rob_head  in  ROB_WIDTH  oldest entry index.
- rob_count  in  ROB_WIDTH+1  occupied entries.
- retire_cnt  out  $clog2(RETIRE_WIDTH+1)  entries retired this cycle; ROB advances head by this amount.
- retire_pr_valid  out  RETIRE_WIDTH  per-slot register commit.
- rd_arch_commit / rd_phy_old_commit / rd_phy_new_commit  out  RETIRE_WIDTH × 5 / PHY_WIDTH / PHY_WIDTH  per-slot commit data.
- retire_store_valid  out  1  one store released to the store buffer.
- retire_branch_valid, update_btb_pc, update_btb_target, update_btb_taken  out  1/ADDR_WIDTH/ADDR_WIDTH/1  BTB update.
- isFlush  out  1  registered redirect pulse.
- targetPC  out  ADDR_WIDTH  redirect target, valid with isFlush.
- retire_done_valid  out  1  SYSTEM retired; sticky in HALT.
- retire_addr  out  ADDR_WIDTH  addr of youngest retired entry this cycle (debug).

## Operation
- FSM states RUN, REDIRECT, HALT; reset → RUN.
- Slot i examines idx=(rob_head+i) mod NUM_ROB_ENTRY. It is eligible only in RUN, with !flush, i<rob_count, ROB_FINISH[idx], and every older slot retiring.
- Prefix stops after (the instruction itself still retires):
  - any BRANCH/JAL/JALR (one BTB update per cycle);
  - any entry with mispredict=1.
- Prefix stops before:
  - a second STORE (one store per cycle);
  - a SYSTEM in slot i>0. SYSTEM retires only from slot 0, alone.
- Commit rules:
  - OP/OP_IMM/LUI/AUIPC/LOAD/JAL/JALR assert retire_pr_valid[i] iff rd_arch≠0.
  - STORE asserts retire_store_valid.
  - BRANCH/JAL/JALR drive the BTB update from update_pc, actual_target and actual_taken.
  - Other opcodes retire with no side effect.
- Non-retiring slots drive zero commit fields.
- Retired mispredict: next state REDIRECT; targetPC ← actual_target.
- Retired SYSTEM: next state HALT.
- REDIRECT: isFlush=1 for exactly one cycle, no retirement, then RUN.
- HALT: no retirement until reset; retire_done_valid held 1.
- flush=1 in any state except HALT: outputs zero, next state RUN, no pending redirect.

## Timing
- Commit, BTB, store and retire_cnt outputs are combinational from the ROB inputs in the same cycle. The ROB and free-list act on the following clk edge.
- Redirect latency: isFlush asserts the cycle after the mispredicted entry retires.
- Reset values: every output 0, state RUN, targetPC 0, perf counters 0.
- Reset takes effect immediately and asynchronously, including mid-REDIRECT; any pending isFlush is lost.
- Head wrap: slot indices wrap modulo NUM_ROB_ENTRY with no bubble.
- rob_count=0: retire_cnt=0.

## Configuration
- RETIRE_PERF_EN defined: adds perf_retired (64-bit, += retire_cnt each cycle) and perf_mispredict (32-bit, +1 per redirect) outputs. Both are cleared by reset and saturate at their maximum value.
- RETIRE_PERF_EN undefined: counters and ports absent; behaviour otherwise identical.

## Test plan
- RETIRE_WIDTH=2, head=14, two finished ALU ops (rd 5, 6) at 14/15 → retire_cnt=2, pr_valid=2'b11; head wraps to 0.
- Finished STORE at slot 0 and STORE at slot 1 → retire_cnt=1, store_valid=1; second store retires the next cycle.
- Slot 0 BRANCH mispredict, target 0x100; slot 1 finished ALU → retire_cnt=1, branch_valid=1. Next cycle isFlush=1, targetPC=0x100, retire_cnt=0.
- Slot 0 ALU, slot 1 SYSTEM → cycle 1 retire_cnt=1. Cycle 2 SYSTEM retires, retire_done_valid=1 and held; no further retires.
- JAL rd=0 finished → retire_pr_valid=0, branch_valid=1. rst_n low during REDIRECT → isFlush=0 immediately.
- Slot 0 unfinished, slot 1 finished → retire_cnt=0; flush=1 with both finished → retire_cnt=0.

Source files
------------

// File: rtl/retire_multi.sv
// rtl/retire_multi.sv - multi-wide in-order ROB retirement; RETIRE_PERF_EN adds perf counters
// ROB entry packing, LSB first: opcode[7], rd_arch[5], rd_phy_old, rd_phy_new, addr, update_pc, actual_taken, actual_target, mispredict
module retire_multi #(
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_ROB_ENTRY = 16,
   parameter int RETIRE_WIDTH  = 2,
   parameter int PHY_WIDTH     = 6,
   localparam int ROB_WIDTH    = $clog2(NUM_ROB_ENTRY),
   localparam int ENTRY_WIDTH  = 14 + 2*PHY_WIDTH + 3*ADDR_WIDTH,
   localparam int CNT_WIDTH    = $clog2(RETIRE_WIDTH+1)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              flush,
   input  logic [NUM_ROB_ENTRY-1:0]          ROB_FINISH,
   input  logic [NUM_ROB_ENTRY*ENTRY_WIDTH-1:0] ROB,
   input  logic [ROB_WIDTH-1:0]              rob_head,
   input  logic [ROB_WIDTH:0]                rob_count,
   output logic [CNT_WIDTH-1:0]              retire_cnt,
   output logic [RETIRE_WIDTH-1:0]           retire_pr_valid,
   output logic [RETIRE_WIDTH*5-1:0]         rd_arch_commit,
   output logic [RETIRE_WIDTH*PHY_WIDTH-1:0] rd_phy_old_commit,
   output logic [RETIRE_WIDTH*PHY_WIDTH-1:0] rd_phy_new_commit,
   output logic                              retire_store_valid,
   output logic                              retire_branch_valid,
   output logic [ADDR_WIDTH-1:0]             update_btb_pc,
   output logic [ADDR_WIDTH-1:0]             update_btb_target,
   output logic                              update_btb_taken,
   output logic                              isFlush,
   output logic [ADDR_WIDTH-1:0]             targetPC,
   output logic                              retire_done_valid,
`ifdef RETIRE_PERF_EN
   output logic [63:0]                       perf_retired,
   output logic [31:0]                       perf_mispredict,
`endif
   output logic [ADDR_WIDTH-1:0]             retire_addr
);

   localparam int OFF_RD   = 7;
   localparam int OFF_OLD  = 12;
   localparam int OFF_NEW  = OFF_OLD + PHY_WIDTH;
   localparam int OFF_ADDR = OFF_NEW + PHY_WIDTH;
   localparam int OFF_UPC  = OFF_ADDR + ADDR_WIDTH;
   localparam int OFF_TK   = OFF_UPC + ADDR_WIDTH;
   localparam int OFF_TGT  = OFF_TK + 1;
   localparam int OFF_MIS  = OFF_TGT + ADDR_WIDTH;

   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [1:0] {S_RUN, S_REDIRECT, S_HALT} state_t;

   state_t                  state;
   logic                    flush_q;
   logic                    done_q;
   logic [ADDR_WIDTH-1:0]   target_q;

   logic                    stop;
   logic                    store_seen;
   logic                    mis_ret;
   logic                    sys_ret;
   logic [ADDR_WIDTH-1:0]   mis_target;
   logic [ROB_WIDTH-1:0]    idx;
   logic [ENTRY_WIDTH-1:0]  ent;
   logic [6:0]              op;
   logic                    is_ctrl;

   always_comb begin
      retire_cnt          = '0;
      retire_pr_valid     = '0;
      rd_arch_commit      = '0;
      rd_phy_old_commit   = '0;
      rd_phy_new_commit   = '0;
      retire_store_valid  = 1'b0;
      retire_branch_valid = 1'b0;
      update_btb_pc       = '0;
      update_btb_target   = '0;
      update_btb_taken    = 1'b0;
      retire_addr         = '0;
      mis_ret             = 1'b0;
      sys_ret             = 1'b0;
      mis_target          = '0;
      store_seen          = 1'b0;
      idx                 = '0;
      ent                 = '0;
      op                  = '0;
      is_ctrl             = 1'b0;
      stop                = (state != S_RUN) || flush || !rst_n;
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
         idx     = ROB_WIDTH'(rob_head + ROB_WIDTH'(i));
         ent     = ROB[idx*ENTRY_WIDTH +: ENTRY_WIDTH];
         op      = ent[6:0];
         is_ctrl = (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
         if (!stop) begin
            // SYSTEM only retires alone from slot 0; a second store waits a cycle
            if ((ROB_WIDTH+1)'(i) >= rob_count || !ROB_FINISH[idx] ||
                (op == OP_SYSTEM && i != 0) || (op == OP_STORE && store_seen)) begin
               stop = 1'b1;
            end else begin
               retire_cnt  = retire_cnt + CNT_WIDTH'(1);
               retire_addr = ent[OFF_ADDR +: ADDR_WIDTH];
               if ((op == OP_OP || op == OP_IMM || op == OP_LUI || op == OP_AUIPC ||
                    op == OP_LOAD || op == OP_JAL || op == OP_JALR) && ent[OFF_RD +: 5] != 5'd0) begin
                  retire_pr_valid[i]                        = 1'b1;
                  rd_arch_commit[i*5 +: 5]                  = ent[OFF_RD +: 5];
                  rd_phy_old_commit[i*PHY_WIDTH +: PHY_WIDTH] = ent[OFF_OLD +: PHY_WIDTH];
                  rd_phy_new_commit[i*PHY_WIDTH +: PHY_WIDTH] = ent[OFF_NEW +: PHY_WIDTH];
               end
               if (op == OP_STORE) begin
                  retire_store_valid = 1'b1;
                  store_seen         = 1'b1;
               end
               if (is_ctrl) begin
                  retire_branch_valid = 1'b1;
                  update_btb_pc       = ent[OFF_UPC +: ADDR_WIDTH];
                  update_btb_target   = ent[OFF_TGT +: ADDR_WIDTH];
                  update_btb_taken    = ent[OFF_TK];
               end
               if (ent[OFF_MIS]) begin
                  mis_ret    = 1'b1;
                  mis_target = ent[OFF_TGT +: ADDR_WIDTH];
               end
               if (op == OP_SYSTEM) sys_ret = 1'b1;
               if (is_ctrl || ent[OFF_MIS] || op == OP_SYSTEM) stop = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_RUN;
         flush_q  <= 1'b0;
         done_q   <= 1'b0;
         target_q <= '0;
      end else if (state != S_HALT && flush) begin
         state   <= S_RUN;
         flush_q <= 1'b0;
      end else begin
         case (state)
            S_RUN: begin
               if (sys_ret) begin
                  state  <= S_HALT;
                  done_q <= 1'b1;
               end else if (mis_ret) begin
                  state    <= S_REDIRECT;
                  flush_q  <= 1'b1;
                  target_q <= mis_target;
               end
            end
            S_REDIRECT: begin
               state   <= S_RUN;
               flush_q <= 1'b0;
            end
            default: state <= S_HALT;
         endcase
      end
   end

   assign isFlush           = flush_q & ~flush;
   assign targetPC          = target_q;
   assign retire_done_valid = done_q;

`ifdef RETIRE_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_retired    <= '0;
         perf_mispredict <= '0;
      end else begin
         if (perf_retired <= ~64'd0 - 64'(retire_cnt)) perf_retired <= perf_retired + 64'(retire_cnt);
         else perf_retired <= '1;
         if (mis_ret && !sys_ret && perf_mispredict != '1) perf_mispredict <= perf_mispredict + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_retire_multi.sv
// tb/tb_retire_multi.sv - directed self-checking bench for retire_multi
module tb_retire_multi;
   localparam int EW = 122;

   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            flush;
   logic [15:0]     rob_finish;
   logic [16*EW-1:0] rob;
   logic [3:0]      rob_head;
   logic [4:0]      rob_count;
   logic [1:0]      retire_cnt;
   logic [1:0]      retire_pr_valid;
   logic [9:0]      rd_arch_commit;
   logic [11:0]     rd_phy_old_commit;
   logic [11:0]     rd_phy_new_commit;
   logic            retire_store_valid;
   logic            retire_branch_valid;
   logic [31:0]     update_btb_pc;
   logic [31:0]     update_btb_target;
   logic            update_btb_taken;
   logic            isFlush;
   logic [31:0]     targetPC;
   logic            retire_done_valid;
   logic [31:0]     retire_addr;
`ifdef RETIRE_PERF_EN
   logic [63:0]     perf_retired;
   logic [31:0]     perf_mispredict;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   retire_multi dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .ROB_FINISH(rob_finish), .ROB(rob),
      .rob_head(rob_head), .rob_count(rob_count), .retire_cnt(retire_cnt),
      .retire_pr_valid(retire_pr_valid), .rd_arch_commit(rd_arch_commit),
      .rd_phy_old_commit(rd_phy_old_commit), .rd_phy_new_commit(rd_phy_new_commit),
      .retire_store_valid(retire_store_valid), .retire_branch_valid(retire_branch_valid),
      .update_btb_pc(update_btb_pc), .update_btb_target(update_btb_target),
      .update_btb_taken(update_btb_taken), .isFlush(isFlush), .targetPC(targetPC),
      .retire_done_valid(retire_done_valid),
`ifdef RETIRE_PERF_EN
      .perf_retired(perf_retired), .perf_mispredict(perf_mispredict),
`endif
      .retire_addr(retire_addr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [EW-1:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [5:0] pold, input logic [5:0] pnew,
                                        input logic [31:0] addr, input logic [31:0] upc,
                                        input logic tk, input logic [31:0] tgt, input logic mis);
      return {mis, tgt, tk, upc, addr, pnew, pold, rd, op};
   endfunction

   task automatic put(input int idx, input logic [EW-1:0] e, input logic fin);
      rob[idx*EW +: EW] = e;
      rob_finish[idx]   = fin;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; rob = '0; rob_finish = '0; rob_head = '0; rob_count = '0;
      @(negedge clk);
      check("rst_cnt", retire_cnt, 0);
      check("rst_isflush", isFlush, 0);
      check("rst_target", targetPC, 0);
      check("rst_done", retire_done_valid, 0);
      next_cycle();
      rst_n = 1'b1;

      // two ALU ops straddling the head wrap
      put(14, mk(OP_OP, 5'd5, 6'd10, 6'd20, 32'h38, 0, 0, 0, 0), 1'b1);
      put(15, mk(OP_OP, 5'd6, 6'd11, 6'd21, 32'h3C, 0, 0, 0, 0), 1'b1);
      rob_head = 4'd14; rob_count = 5'd2;
      @(negedge clk);
      check("wrap_cnt", retire_cnt, 2);
      check("wrap_prv", retire_pr_valid, 2'b11);
      check("wrap_rd", rd_arch_commit, {5'd6, 5'd5});
      check("wrap_old", rd_phy_old_commit, {6'd11, 6'd10});
      check("wrap_new", rd_phy_new_commit, {6'd21, 6'd20});
      check("wrap_addr", retire_addr, 32'h3C);
      next_cycle();

      // back-to-back stores, one per cycle
      put(0, mk(OP_STORE, 5'd0, 0, 0, 32'h40, 0, 0, 0, 0), 1'b1);
      put(1, mk(OP_STORE, 5'd0, 0, 0, 32'h44, 0, 0, 0, 0), 1'b1);
      rob_head = 4'd0; rob_count = 5'd2;
      @(negedge clk);
      check("st1_cnt", retire_cnt, 1);
      check("st1_valid", retire_store_valid, 1);
      check("st1_addr", retire_addr, 32'h40);
      next_cycle();
      rob_head = 4'd1; rob_count = 5'd1;
      @(negedge clk);
      check("st2_cnt", retire_cnt, 1);
      check("st2_valid", retire_store_valid, 1);
      check("st2_addr", retire_addr, 32'h44);
      next_cycle();

      // mispredicted branch then redirect
      put(2, mk(OP_BRANCH, 5'd0, 0, 0, 32'h80, 32'h80, 1'b1, 32'h100, 1'b1), 1'b1);
      put(3, mk(OP_OP, 5'd7, 6'd12, 6'd22, 32'h84, 0, 0, 0, 0), 1'b1);
      rob_head = 4'd2; rob_count = 5'd2;
      @(negedge clk);
      check("br_cnt", retire_cnt, 1);
      check("br_valid", retire_branch_valid, 1);
      check("br_pc", update_btb_pc, 32'h80);
      check("br_tgt", update_btb_target, 32'h100);
      check("br_taken", update_btb_taken, 1);
      check("br_prv", retire_pr_valid, 0);
      check("br_noflush", isFlush, 0);
      next_cycle();
      rob_head = 4'd3; rob_count = 5'd1;
      @(negedge clk);
      check("rd_isflush", isFlush, 1);
      check("rd_target", targetPC, 32'h100);
      check("rd_cnt", retire_cnt, 0);
      next_cycle();
      @(negedge clk);
      check("post_isflush", isFlush, 0);
      check("post_cnt", retire_cnt, 1);
      check("post_prv", retire_pr_valid, 2'b01);
      next_cycle();

      // JAL to x0 mispredict, then asynchronous reset mid-redirect
      put(4, mk(OP_JAL, 5'd0, 0, 0, 32'h90, 32'h90, 1'b1, 32'h200, 1'b1), 1'b1);
      rob_head = 4'd4; rob_count = 5'd1;
      @(negedge clk);
      check("jal_cnt", retire_cnt, 1);
      check("jal_prv", retire_pr_valid, 0);
      check("jal_br", retire_branch_valid, 1);
      next_cycle();
      rob_count = 5'd0;
      @(negedge clk);
      check("jal_isflush", isFlush, 1);
      check("jal_target", targetPC, 32'h200);
      #2 rst_n = 1'b0;
      #1;
      check("arst_isflush", isFlush, 0);
      check("arst_target", targetPC, 0);
      next_cycle();
      rst_n = 1'b1;

      // unfinished head blocks; external flush kills retirement
      put(5, mk(OP_OP, 5'd9, 0, 0, 32'hA0, 0, 0, 0, 0), 1'b0);
      put(6, mk(OP_OP, 5'd10, 0, 0, 32'hA4, 0, 0, 0, 0), 1'b1);
      rob_head = 4'd5; rob_count = 5'd2;
      @(negedge clk);
      check("unfin_cnt", retire_cnt, 0);
      rob_finish[5] = 1'b1;
      flush = 1'b1;
      #1;
      check("flush_cnt", retire_cnt, 0);
      check("flush_prv", retire_pr_valid, 0);
      next_cycle();
      flush = 1'b0;

      // SYSTEM waits for slot 0, then halts
      put(7, mk(OP_OP, 5'd8, 0, 0, 32'hB0, 0, 0, 0, 0), 1'b1);
      put(8, mk(OP_SYSTEM, 5'd0, 0, 0, 32'hB4, 0, 0, 0, 0), 1'b1);
      put(9, mk(OP_OP, 5'd11, 0, 0, 32'hB8, 0, 0, 0, 0), 1'b1);
      rob_head = 4'd7; rob_count = 5'd2;
      @(negedge clk);
      check("sys1_cnt", retire_cnt, 1);
      check("sys1_prv", retire_pr_valid, 2'b01);
      next_cycle();
      rob_head = 4'd8; rob_count = 5'd1;
      @(negedge clk);
      check("sys2_cnt", retire_cnt, 1);
      check("sys2_done", retire_done_valid, 0);
      next_cycle();
      rob_head = 4'd9; rob_count = 5'd1;
      @(negedge clk);
      check("halt_done", retire_done_valid, 1);
      check("halt_cnt", retire_cnt, 0);
      next_cycle();
      flush = 1'b1;
      @(negedge clk);
      check("halt_flush_done", retire_done_valid, 1);
      check("halt_flush_cnt", retire_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
